apb_mdio_controller: RTL
========================

Name: apb_mdio_controller

Overview:
- APB completer that turns management register accesses into IEEE 802.3 Clause 22 MDIO frames to the PHY.
- Sits downstream of the management APB register slice as the endpoint on the MDIO bus segment (device window 0x000_800).
- Handles one read or write transaction at a time; firmware polls the busy bit or waits for the done pulse.

Parameters:
- CLK_DIV, 50, clk cycles per MDC half-period (250 MHz / 100 = 2.5 MHz MDC); must be ≥2.
- ADDR_WIDTH, 11, APB address width.

Ports:
- clk  in  1  system clock; APB and MDIO logic in this single domain.
- rst  in  1  asynchronous, active-high reset.
- apb_psel  in  1  APB select.
- apb_penable  in  1  APB enable (access phase).
- apb_pwrite  in  1  1 = write.
- apb_paddr  in  ADDR_WIDTH  byte address.
- apb_pwdata  in  16  write data.
- apb_pready  out  1  transfer complete.
- apb_prdata  out  16  read data.
- apb_pslverr  out  1  error response.
- mdc  out  1  MDIO clock.
- mdio_out  out  1  MDIO data driven to pad.
- mdio_oe  out  1  1 = drive mdio_out onto pad.
- mdio_in  in  1  pad input, already synchronized externally.
- done  out  1  one-cycle pulse at transaction end.

Behaviour:
- Reset: apb_pready=0, apb_prdata=0, apb_pslverr=0, mdc=0, mdio_out=1, mdio_oe=0, done=0. State=IDLE. DATA=0. Busy=0.
- Reset mid-frame aborts the frame immediately. No partial completion. done is not pulsed.
- Register map, 16-bit:
  - 0x000 CMD (W/R): [4:0] REGAD, [9:5] PHYAD, [15] 1=write/0=read. A write while idle latches the fields and starts a frame.
  - 0x002 DATA (W/R): write data for the next write frame; holds the result after a read frame.
  - 0x004 STATUS (R): [0] busy; all other bits read 0.
- APB: pready asserts for exactly one cycle, the cycle after psel&penable (one wait state); deasserts the next cycle. prdata is valid with pready and is 0 otherwise.
- pslverr=1 with pready in these cases:
  - unmapped address; reads return 0.
  - write to STATUS.
  - write to CMD or DATA while busy; the write is ignored and state is unchanged.
- Busy=1 from the cycle after the accepted CMD write until the cycle done pulses, inclusive of the done cycle → cleared the next cycle.
- MDC: a divider counts 0..CLK_DIV-1 and toggles mdc at terminal count, only while busy. mdc idles low.
- Data launch and sampling: mdio_out changes one clk after each MDC falling edge. mdio_in is sampled on the clk cycle of each MDC rising edge.
- Frame: 64 bit-times, MSB first.
  - Preamble: 32 ones.
  - ST: 01.
  - OP: 01 for write, 10 for read.
  - PHYAD: 5 bits. REGAD: 5 bits.
  - TA: 10 for write. For read, mdio_oe drops at the start of TA.
  - Data: 16 bits. For read, the 16 sampled bits shift into DATA; the TA sample is ignored.
- States: IDLE → PREAMBLE(32) → HEADER(14) → TA(2) → DATA(16) → DONE(1 clk: pulse done, mdc=0, mdio_oe=0, mdio_out=1) → IDLE.
  - A 6-bit bit counter advances on each MDC falling edge.
- mdio_oe is 1 from PREAMBLE start through DATA end for writes, and from PREAMBLE start through HEADER end for reads.
- Total latency: 64·2·CLK_DIV clk cycles from busy rise to done, ±1 cycle for DONE.
- Simultaneous APB read of DATA in the cycle done pulses returns the new read result.

Optional Feature:
- Macro MDIO_PREAMBLE_SUPPRESS_EN.
- Defined: CMD[14] becomes writable. CMD[14]=1 skips the PREAMBLE state, giving a 32-bit frame with latency 32·2·CLK_DIV. CMD[14] reads back as written.
- Undefined: CMD[14] is ignored and reads 0; every frame has the full 32-bit preamble.

Test Plan:
- Reset, then read STATUS and DATA → prdata=0x0000, pslverr=0. mdio_oe=0, mdc=0, mdio_out=1.
- CLK_DIV=4; write DATA=0xBEEF, then CMD=0x8000|(0x01<<5)|0x04 → decoded mdio_out bits after the preamble are 01 01 00001 00100 10 1011111011101111. mdio_oe high for all 64 bits. done pulses at ~512 cycles; busy then clears.
- CLK_DIV=4; read CMD with PHYAD=0x03, REGAD=0x02; PHY model drives 0x1234 on mdio_in during DATA → mdio_oe falls at TA start, DATA reads 0x1234 after done, STATUS=0.
- During a busy frame, write CMD=0x0000 → pslverr=1. The in-flight frame completes unaltered. Write DATA while busy → pslverr=1, DATA unchanged.
- Access 0x006 → pslverr=1, prdata=0. Write STATUS → pslverr=1.
- Assert rst at bit 20 of a frame → all outputs return to reset values the same cycle. No done pulse. Busy=0 after release. A new CMD then runs a full 64-bit frame. With MDIO_PREAMBLE_SUPPRESS_EN defined and CMD[14]=1: 32-bit frame, done at ~256 cycles.

Source files
------------

// File: rtl/apb_mdio_controller.sv
// rtl/apb_mdio_controller.sv - APB completer that issues IEEE 802.3 Clause 22 MDIO frames
//
// Purpose:
//    Turns APB register accesses into single Clause 22 MDIO read/write frames.
//    One transaction at a time; firmware polls STATUS.busy or waits for done.
//
// Registers (16-bit, byte addressed):
//    0x000 CMD    [4:0] REGAD, [9:5] PHYAD, [14] preamble suppress (optional), [15] 1=write
//    0x002 DATA   write data for the next write frame / result of the last read frame
//    0x004 STATUS [0] busy (read only)
//
// Ports:
//    clk, rst                 system clock, asynchronous active-high reset
//    apb_psel/penable/pwrite  APB control
//    apb_paddr, apb_pwdata    APB address / write data
//    apb_pready               one-cycle completion, one wait state
//    apb_prdata, apb_pslverr  read data / error response, valid with apb_pready
//    mdc                      MDIO clock, idles low
//    mdio_out, mdio_oe        pad data and output enable
//    mdio_in                  pad input, already synchronized
//    done                     one-cycle pulse at transaction end
//
// Optional feature macro: MDIO_PREAMBLE_SUPPRESS_EN
//    Defined:   CMD[14]=1 skips the 32-bit preamble; CMD[14] reads back as written.
//    Undefined: CMD[14] is ignored and reads 0.

module apb_mdio_controller #(
   parameter int CLK_DIV    = 50,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  apb_psel,
   input  logic                  apb_penable,
   input  logic                  apb_pwrite,
   input  logic [ADDR_WIDTH-1:0] apb_paddr,
   input  logic [15:0]           apb_pwdata,
   output logic                  apb_pready,
   output logic [15:0]           apb_prdata,
   output logic                  apb_pslverr,
   output logic                  mdc,
   output logic                  mdio_out,
   output logic                  mdio_oe,
   input  logic                  mdio_in,
   output logic                  done
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [ADDR_WIDTH-1:0] ADDR_CMD    = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_DATA   = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(4);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_HEADER,
      S_TA,
      S_DATA,
      S_DONE
   } state_t;

   state_t           state;
   logic [5:0]       bit_cnt;   // index into the 64-bit frame, advances on MDC falling edges
   logic [DIV_W-1:0] div_cnt;
   logic             launch;    // one clk after an MDC falling edge: drive the next bit
   logic             cmd_write;
   logic             cmd_suppress;
   logic [4:0]       phyad;
   logic [4:0]       regad;
   logic [15:0]      data_reg;

   logic             busy;
   logic             access;
   logic             suppress_req;
   logic [63:0]      frame;
   logic [15:0]      cmd_rd;
   logic             unused_pwdata;

   assign busy   = (state != S_IDLE);
   // Trigger once per transfer: the master holds psel&penable through the pready cycle.
   assign access = apb_psel & apb_penable & ~apb_pready;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   assign suppress_req = apb_pwdata[14];
`else
   assign suppress_req = 1'b0;
`endif

   assign unused_pwdata = ^apb_pwdata[14:10];

   // Full frame image, MSB first. Read frames carry don't-care ones in TA/DATA,
   // which are never driven because mdio_oe is low there.
   assign frame = {32'hFFFF_FFFF, 2'b01,
                   cmd_write ? 2'b01 : 2'b10,
                   phyad, regad,
                   cmd_write ? 2'b10 : 2'b11,
                   cmd_write ? data_reg : 16'hFFFF};

   assign cmd_rd = {cmd_write, cmd_suppress, 4'b0000, phyad, regad};

   function automatic state_t phase_of(input logic [5:0] b);
      if (b < 6'd32)      return S_PREAMBLE;
      else if (b < 6'd46) return S_HEADER;
      else if (b < 6'd48) return S_TA;
      else                return S_DATA;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         apb_pready   <= 1'b0;
         apb_prdata   <= 16'h0000;
         apb_pslverr  <= 1'b0;
         mdc          <= 1'b0;
         mdio_out     <= 1'b1;
         mdio_oe      <= 1'b0;
         done         <= 1'b0;
         state        <= S_IDLE;
         bit_cnt      <= 6'd0;
         div_cnt      <= '0;
         launch       <= 1'b0;
         cmd_write    <= 1'b0;
         cmd_suppress <= 1'b0;
         phyad        <= 5'd0;
         regad        <= 5'd0;
         data_reg     <= 16'h0000;
      end else begin
         apb_pready  <= 1'b0;
         apb_prdata  <= 16'h0000;
         apb_pslverr <= 1'b0;
         done        <= 1'b0;
         launch      <= 1'b0;

         // APB register access
         if (access) begin
            apb_pready <= 1'b1;
            if (apb_paddr == ADDR_CMD) begin
               if (!apb_pwrite) begin
                  apb_prdata <= cmd_rd;
               end else if (busy) begin
                  apb_pslverr <= 1'b1;
               end else begin
                  cmd_write    <= apb_pwdata[15];
                  cmd_suppress <= suppress_req;
                  phyad        <= apb_pwdata[9:5];
                  regad        <= apb_pwdata[4:0];
                  div_cnt      <= '0;
                  mdc          <= 1'b0;
                  mdio_oe      <= 1'b1;
                  // First bit is a preamble one, or ST's leading zero when suppressed.
                  mdio_out     <= ~suppress_req;
                  if (suppress_req) begin
                     state   <= S_HEADER;
                     bit_cnt <= 6'd32;
                  end else begin
                     state   <= S_PREAMBLE;
                     bit_cnt <= 6'd0;
                  end
               end
            end else if (apb_paddr == ADDR_DATA) begin
               if (!apb_pwrite) begin
                  apb_prdata <= data_reg;
               end else if (busy) begin
                  apb_pslverr <= 1'b1;
               end else begin
                  data_reg <= apb_pwdata;
               end
            end else if (apb_paddr == ADDR_STATUS) begin
               if (apb_pwrite) apb_pslverr <= 1'b1;
               else            apb_prdata  <= {15'd0, busy};
            end else begin
               apb_pslverr <= 1'b1;
            end
         end

         // Frame engine; new frames only start from IDLE, so no overlap with the above.
         case (state)
            S_IDLE: begin
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               if (launch) begin
                  mdio_out <= frame[6'd63 - bit_cnt];
                  mdio_oe  <= cmd_write | (bit_cnt < 6'd46);
               end
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  mdc     <= ~mdc;
                  if (!mdc) begin
                     // MDC rising: sample read data; the TA sample is not used.
                     if (!cmd_write && bit_cnt >= 6'd48)
                        data_reg <= {data_reg[14:0], mdio_in};
                  end else if (bit_cnt == 6'd63) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     mdio_oe  <= 1'b0;
                     mdio_out <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 6'd1;
                     state   <= phase_of(bit_cnt + 6'd1);
                     launch  <= 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule
